planar_fetch: RTL and testbench

PLANAR_FETCH -- requirements
Module: planar_fetch

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/plane_shifter.sv | 26 ++
 rtl/planar_fetch.sv | 151 +++++++++++++++
 tb/tb_planar_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared phase encodings, active-area extent and default memory
// map for the planar bitplane fetch block.
package fetch_pkg;

  // Position of the prefetch column within its 8-pixel group (fx[2:0]).
  typedef enum logic [2:0] {
    PH_FETCH0 = 3'd0,
    PH_FETCH1 = 3'd1,
    PH_FETCH2 = 3'd2,
    PH_FETCH3 = 3'd3,
    PH_IDLE4  = 3'd4,
    PH_IDLE5  = 3'd5,
    PH_CPU    = 3'd6,
    PH_LOAD   = 3'd7
  } phase_e;

  localparam int MAX_PLANES    = 4;
  localparam int ACTIVE_EXTENT = 256;

  localparam logic signed [12:0] EXTENT_S = 13'(ACTIVE_EXTENT);

  localparam logic [15:0] DEFAULT_SCREEN_BASE  = 16'h8000;
  localparam logic [15:0] DEFAULT_PLANE_STRIDE = 16'h2000;
  localparam logic [7:0]  SCROLL_INIT          = 8'hFF;

  // True when a signed coordinate lies in 0..ACTIVE_EXTENT-1.
  function automatic logic in_extent(input logic signed [12:0] c);
    return (c >= 13'sd0) && (c < EXTENT_S);
  endfunction

endpackage

// File: rtl/plane_shifter.sv
// plane_shifter: one bitplane's 8-bit pixel shift register. Loaded at the
// start of a group, then shifted left so the next pixel sits in the MSB.
module plane_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       msb
);

  logic [7:0] sr;

  // Load a fresh byte at group start, otherwise advance one pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= 8'h00;
    end else if (load) begin
      sr <= din;
    end else begin
      sr <= {sr[6:0], 1'b0};
    end
  end

  assign msb = sr[7];

endmodule

// File: rtl/planar_fetch.sv
// planar_fetch: bitplane video fetch. Reads PLANES bytes per 8-pixel group
// on phases 0..PLANES-1, captures them one clock later, loads the plane
// shifters on phase 7 and serialises them into a 4-bit palette index.
// A CPU slot is granted on phase 6, which never overlaps a fetch.
//
// Optional feature: define PLANAR_FETCH_SCROLL_EN to enable the vertical
// scroll register (latched at the frame interrupt). Without it the scroll
// input is ignored and the row offset is fixed at 8'hFF - fy[7:0].
module planar_fetch
  import fetch_pkg::*;
#(
  parameter int          PLANES       = 4,
  parameter logic [15:0] SCREEN_BASE  = DEFAULT_SCREEN_BASE,
  parameter logic [15:0] PLANE_STRIDE = DEFAULT_PLANE_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [12:0] fx,
  input  logic signed [12:0] fy,
  input  logic [7:0]         scroll,
  input  logic [3:0]         border_idx,
  input  logic [7:0]         mem_data,
  output logic [15:0]        mem_addr,
  output logic               mem_rd,
  input  logic               cpu_req,
  output logic               cpu_grant,
  output logic [3:0]         pix_idx,
  output logic               pix_active,
  output logic               frame_irq
);

  phase_e            phase;
  logic              active;
  logic              frame_start;
  logic              load;
  logic              fetch_en;
  logic              rd_q;
  logic              group_active;
  logic              pix_en;
  logic [7:0]        scroll_q;
  logic [7:0]        row;
  logic [15:0]       plane_off;
  logic [15:0]       col_off;
  logic [7:0]        prefetch [PLANES];
  logic [PLANES-1:0] plane_msb;
  logic [3:0]        pix_bits;

  assign phase       = phase_e'(fx[2:0]);
  assign active      = in_extent(fx) && in_extent(fy);
  assign frame_start = (fy == EXTENT_S) && (fx == 13'sd0);
  assign load        = (phase == PH_LOAD);
  assign row         = scroll_q - fy[7:0];
  assign plane_off   = PLANE_STRIDE * {13'd0, fx[2:0]};
  assign col_off     = {3'b000, fx[7:3], 8'h00};

`ifdef PLANAR_FETCH_SCROLL_EN
  // Scroll takes effect only at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_q <= SCROLL_INIT;
    end else if (frame_start) begin
      scroll_q <= scroll;
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^scroll;
  assign scroll_q      = SCROLL_INIT;
`endif

  // Fetch address/strobe; fetch_en holds reads off after reset until a group
  // boundary so a partially fetched group is never used.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    if (!reset && (fetch_en || phase == PH_FETCH0) && active &&
        (int'(phase) < PLANES)) begin
      mem_rd   = 1'b1;
      mem_addr = SCREEN_BASE + plane_off + col_off + {8'h00, row};
    end
  end

  // Sequencing flags: fetch resume, read-data tracking, group/pixel state.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_en     <= 1'b0;
      rd_q         <= 1'b0;
      group_active <= 1'b0;
      pix_en       <= 1'b0;
    end else begin
      rd_q <= mem_rd;
      if (phase == PH_FETCH0) begin
        fetch_en <= 1'b1;
      end
      if (load) begin
        group_active <= active;
        pix_en       <= 1'b1;
      end
    end
  end

  // Read data arrives one clock after the strobe, so phase p+1 owns plane p.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PLANES; p++) begin
        prefetch[p] <= 8'h00;
      end
    end else begin
      for (int p = 0; p < PLANES; p++) begin
        if (rd_q && (int'(phase) == p + 1)) begin
          prefetch[p] <= mem_data;
        end
      end
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    plane_shifter u_shifter (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .din   (active ? prefetch[p] : 8'h00),
      .msb   (plane_msb[p])
    );
  end

  // Plane 0 is the index MSB; planes not built read as zero.
  for (genvar i = 0; i < MAX_PLANES; i++) begin : g_pix
    if (i < PLANES) begin : g_present
      assign pix_bits[3-i] = plane_msb[i];
    end else begin : g_absent
      assign pix_bits[3-i] = 1'b0;
    end
  end

  // Border colour outside the active area; zero until the first group loads
  // after reset.
  always_comb begin
    pix_idx = 4'h0;
    if (group_active) begin
      pix_idx = pix_bits;
    end else if (pix_en) begin
      pix_idx = border_idx;
    end
  end

  assign pix_active = group_active;
  assign cpu_grant  = !reset && (phase == PH_CPU) && cpu_req;
  assign frame_irq  = !reset && frame_start;

endmodule

// File: tb/tb_planar_fetch.sv
// tb_planar_fetch: directed table plus corner-case sequences for planar_fetch
// with PLANES=4 (u4) and PLANES=2 (u2) sharing one set of inputs.
module tb_planar_fetch;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [12:0] fx, fy;
  logic [7:0]         scroll;
  logic [3:0]         border_idx;
  logic [7:0]         mem_data;
  logic               cpu_req;

  logic [15:0] a4, a2;
  logic        rd4, rd2, gr4, gr2, act4, act2, irq4, irq2;
  logic [3:0]  pix4, pix2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  planar_fetch #(.PLANES(4)) u4 (
    .clk(clk), .reset(reset), .fx(fx), .fy(fy), .scroll(scroll),
    .border_idx(border_idx), .mem_data(mem_data), .mem_addr(a4),
    .mem_rd(rd4), .cpu_req(cpu_req), .cpu_grant(gr4), .pix_idx(pix4),
    .pix_active(act4), .frame_irq(irq4)
  );

  planar_fetch #(.PLANES(2)) u2 (
    .clk(clk), .reset(reset), .fx(fx), .fy(fy), .scroll(scroll),
    .border_idx(border_idx), .mem_data(mem_data), .mem_addr(a2),
    .mem_rd(rd2), .cpu_req(cpu_req), .cpu_grant(gr2), .pix_idx(pix2),
    .pix_active(act2), .frame_irq(irq2)
  );

  typedef struct {
    int          fx;
    logic        req;
    logic [7:0]  md;
    logic        rd;
    logic [15:0] addr;
    logic [3:0]  pix;
    logic        act;
    logic        grant;
    logic        rd2;
    logic [3:0]  pix2;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input int f, input logic rq, input logic [7:0] md,
                              input logic rd, input logic [15:0] ad,
                              input logic [3:0] px, input logic ac,
                              input logic gr, input logic r2,
                              input logic [3:0] p2);
    vec_t v;
    v.fx = f; v.req = rq; v.md = md; v.rd = rd; v.addr = ad; v.pix = px;
    v.act = ac; v.grant = gr; v.rd2 = r2; v.pix2 = p2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int fxv, input int fyv, input logic rq,
                      input logic [7:0] md, input logic rst);
    @(posedge clk);
    #1;
    fx       = 13'(fxv);
    fy       = 13'(fyv);
    cpu_req  = rq;
    mem_data = md;
    reset    = rst;
    @(negedge clk);
  endtask

  initial begin
    int grants4, grants2, reads4, reads2, bad, pulses4, pulses2, first4, first2;
    logic [15:0] exp_a;

    reset = 1'b1; fx = '0; fy = '0; scroll = 8'hFF; border_idx = 4'h5;
    mem_data = 8'h00; cpu_req = 1'b1;

    // group -1 (inactive), group 0 (bytes 80,00,00,00), group 1 (C0,40,80,00)
    vecs[0]  = mk(-8, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[1]  = mk(-7, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[2]  = mk(-6, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[3]  = mk(-5, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[4]  = mk(-4, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[5]  = mk(-3, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[6]  = mk(-2, 1, 8'h00, 0, 16'h0000, 4'h0, 0, 1, 0, 4'h0);
    vecs[7]  = mk(-1, 0, 8'h00, 0, 16'h0000, 4'h0, 0, 0, 0, 4'h0);
    vecs[8]  = mk( 0, 0, 8'h00, 1, 16'h80FF, 4'h5, 0, 0, 1, 4'h5);
    vecs[9]  = mk( 1, 0, 8'h80, 1, 16'hA0FF, 4'h5, 0, 0, 1, 4'h5);
    vecs[10] = mk( 2, 1, 8'h00, 1, 16'hC0FF, 4'h5, 0, 0, 0, 4'h5);
    vecs[11] = mk( 3, 0, 8'h00, 1, 16'hE0FF, 4'h5, 0, 0, 0, 4'h5);
    vecs[12] = mk( 4, 0, 8'h00, 0, 16'h0000, 4'h5, 0, 0, 0, 4'h5);
    vecs[13] = mk( 5, 0, 8'h00, 0, 16'h0000, 4'h5, 0, 0, 0, 4'h5);
    vecs[14] = mk( 6, 1, 8'h00, 0, 16'h0000, 4'h5, 0, 1, 0, 4'h5);
    vecs[15] = mk( 7, 0, 8'h00, 0, 16'h0000, 4'h5, 0, 0, 0, 4'h5);
    vecs[16] = mk( 8, 0, 8'h00, 1, 16'h81FF, 4'h8, 1, 0, 1, 4'h8);
    vecs[17] = mk( 9, 0, 8'hC0, 1, 16'hA1FF, 4'h0, 1, 0, 1, 4'h0);
    vecs[18] = mk(10, 0, 8'h40, 1, 16'hC1FF, 4'h0, 1, 0, 0, 4'h0);
    vecs[19] = mk(11, 0, 8'h80, 1, 16'hE1FF, 4'h0, 1, 0, 0, 4'h0);
    vecs[20] = mk(12, 0, 8'h00, 0, 16'h0000, 4'h0, 1, 0, 0, 4'h0);
    vecs[21] = mk(13, 0, 8'h00, 0, 16'h0000, 4'h0, 1, 0, 0, 4'h0);
    vecs[22] = mk(14, 1, 8'h00, 0, 16'h0000, 4'h0, 1, 1, 0, 4'h0);
    vecs[23] = mk(15, 0, 8'h00, 0, 16'h0000, 4'h0, 1, 0, 0, 4'h0);
    vecs[24] = mk(16, 0, 8'h00, 1, 16'h82FF, 4'hA, 1, 0, 1, 4'h8);
    vecs[25] = mk(17, 0, 8'h00, 1, 16'hA2FF, 4'hC, 1, 0, 1, 4'hC);

    // reset state, including strobes that reset must suppress
    step(0, 0, 1, 8'h00, 1);
    step(0, 0, 1, 8'h00, 1);
    chk("rst_rd", 32'(rd4), 32'(0));
    chk("rst_addr", 32'(a4), 32'(0));
    chk("rst_pix", 32'(pix4), 32'(0));
    chk("rst_act", 32'(act4), 32'(0));
    chk("rst_rd2", 32'(rd2), 32'(0));
    step(0, 256, 1, 8'h00, 1);
    chk("rst_irq", 32'(irq4), 32'(0));
    step(6, 0, 1, 8'h00, 1);
    chk("rst_grant", 32'(gr4), 32'(0));

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].fx, 0, vecs[i].req, vecs[i].md, 1'b0);
      chk($sformatf("v%0d_rd", i), 32'(rd4), 32'(vecs[i].rd));
      chk($sformatf("v%0d_addr", i), 32'(a4), 32'(vecs[i].addr));
      chk($sformatf("v%0d_pix", i), 32'(pix4), 32'(vecs[i].pix));
      chk($sformatf("v%0d_act", i), 32'(act4), 32'(vecs[i].act));
      chk($sformatf("v%0d_grant", i), 32'(gr4), 32'(vecs[i].grant));
      chk($sformatf("v%0d_irq", i), 32'(irq4), 32'(0));
      chk($sformatf("v%0d_rd2", i), 32'(rd2), 32'(vecs[i].rd2));
      chk($sformatf("v%0d_addr2", i), 32'(a2), 32'(vecs[i].rd2 ? vecs[i].addr : 16'h0000));
      chk($sformatf("v%0d_pix2", i), 32'(pix2), 32'(vecs[i].pix2));
      chk($sformatf("v%0d_act2", i), 32'(act2), 32'(vecs[i].act));
    end

    // scroll written mid-frame stays invisible until the frame boundary
    scroll = 8'h10;
    step(0, 100, 0, 8'h00, 0);
    chk("scroll_mid_a", 32'(a4), 32'(16'h809B));
    step(0, 101, 0, 8'h00, 0);
    chk("scroll_mid_b", 32'(a4), 32'(16'h809A));
    pulses4 = 0; pulses2 = 0;
    for (int f = -3; f <= 3; f++) begin
      step(f, 256, 0, 8'h00, 0);
      if (irq4) pulses4++;
      if (irq2) pulses2++;
      if (f == 0) chk("irq_at_origin", 32'(irq4), 32'(1));
    end
    chk("irq_pulses", 32'(pulses4), 32'(1));
    chk("irq_pulses2", 32'(pulses2), 32'(1));
    scroll = 8'h33;
`ifdef PLANAR_FETCH_SCROLL_EN
    exp_a = 16'h8010;
`else
    exp_a = 16'h80FF;
`endif
    step(0, 0, 0, 8'h00, 0);
    chk("scroll_new_frame", 32'(a4), 32'(exp_a));
    step(1, 0, 0, 8'h00, 0);
    chk("scroll_new_frame_p1", 32'(a4), 32'(exp_a + 16'h2000));

    // cpu_req held high: one grant per group, only at phase 6, never on a read
    grants4 = 0; grants2 = 0; reads4 = 0; reads2 = 0; bad = 0;
    for (int f = 0; f < 32; f++) begin
      step(f, 5, 1, 8'h00, 0);
      if (gr4) begin
        grants4++;
        if (f % 8 != 6) bad++;
        if (rd4) bad++;
      end
      if (gr2) grants2++;
      if (rd4) reads4++;
      if (rd2) reads2++;
    end
    chk("grant_count", 32'(grants4), 32'(4));
    chk("grant_count2", 32'(grants2), 32'(4));
    chk("grant_misplaced", 32'(bad), 32'(0));
    chk("reads_per_4groups", 32'(reads4), 32'(16));
    chk("reads_per_4groups2", 32'(reads2), 32'(8));

    // reset at phase 2: everything quiet after, next read waits for phase 0
    step(16, 10, 1, 8'h00, 0);
    step(17, 10, 1, 8'h00, 0);
    step(18, 10, 1, 8'h00, 1);
    chk("midrst_rd_during", 32'(rd4), 32'(0));
    step(19, 10, 1, 8'h00, 0);
    chk("midrst_rd", 32'(rd4), 32'(0));
    chk("midrst_addr", 32'(a4), 32'(0));
    chk("midrst_pix", 32'(pix4), 32'(0));
    chk("midrst_act", 32'(act4), 32'(0));
    chk("midrst_grant", 32'(gr4), 32'(0));
    chk("midrst_irq", 32'(irq4), 32'(0));
    first4 = -1; first2 = -1;
    for (int f = 20; f < 36; f++) begin
      step(f, 10, 1, 8'h00, 0);
      if (rd4 && first4 < 0) first4 = f;
      if (rd2 && first2 < 0) first2 = f;
    end
    chk("midrst_first_read", 32'(first4), 32'(24));
    chk("midrst_first_read2", 32'(first2), 32'(24));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
